// File: rtl/dm_unit_if.sv
// MEM-stage data-memory port bundle: the pipeline drives the address and store side,
// the memory returns the extended load value and the misalignment flag.
interface dm_unit_if #(parameter int PC_WIDTH = 32);
  logic [PC_WIDTH-1:0] pc;
  logic [31:0]         addr;
  logic [31:0]         wdata;
  logic                mem_write;
  logic [1:0]          st_type;
  logic [2:0]          ld_type;
  logic [31:0]         rdata;
  logic                align_err;

  modport master (output pc, addr, wdata, mem_write, st_type, ld_type,
                  input  rdata, align_err);
  modport slave  (input  pc, addr, wdata, mem_write, st_type, ld_type,
                  output rdata, align_err);
endinterface

// File: rtl/dm_unit.sv
// MEM-stage data memory: byte/half/word stores on the clock edge, combinational
// extended loads, misalignment detection, and a commit log for simulation.
module dm_lane (
  input  logic       be,
  input  logic [7:0] old_b,
  input  logic [7:0] new_b,
  output logic [7:0] merged_b
);
  assign merged_b = be ? new_b : old_b;
endmodule

module dm_unit #(
  parameter int ADDR_WIDTH = 10,
  parameter int PC_WIDTH   = 32
) (
  input  logic      clk,
  input  logic      reset,
  dm_unit_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0]           mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wi;
  logic [1:0]            bo;
  logic [31:0]           cur, wlane, merged;
  logic [3:0]            be;
  logic                  ld_byte, ld_half, ld_mis, st_mis, we;
  logic [7:0]            sel_b;
  logic [15:0]           sel_h;
  logic [PC_WIDTH-1:0]   log_pc;

  // Upper address bits are dropped, so addresses alias modulo the memory size.
  assign wi      = bus.addr[ADDR_WIDTH+1:2];
  assign bo      = bus.addr[1:0];
  assign cur     = mem[wi];
  assign log_pc  = bus.pc;
  assign ld_byte = (bus.ld_type == 3'd1) || (bus.ld_type == 3'd2);
  assign ld_half = (bus.ld_type == 3'd3) || (bus.ld_type == 3'd4);
  assign ld_mis  = ld_half ? bo[0] : (ld_byte ? 1'b0 : (bo != 2'b00));

  always_comb begin
    st_mis = 1'b0;
    be     = 4'b0000;
    wlane  = bus.wdata;
    case (bus.st_type)
      2'b00: begin
        st_mis = (bo != 2'b00);
        be     = 4'b1111;
      end
      2'b01: begin
        st_mis = bo[0];
        be     = bo[1] ? 4'b1100 : 4'b0011;
        wlane  = {2{bus.wdata[15:0]}};
      end
      2'b10: begin
        be     = 4'b0001 << bo;
        wlane  = {4{bus.wdata[7:0]}};
      end
      default: be = 4'b0000;
    endcase
  end

  // Store-side misalignment only counts when a store is actually requested.
  assign bus.align_err = ld_mis | (bus.mem_write & st_mis);
  assign we = bus.mem_write & ~reset & ~bus.align_err & (bus.st_type != 2'b11);

  for (genvar l = 0; l < 4; l++) begin : g_lane
    dm_lane u_lane (
      .be       (be[l]),
      .old_b    (cur[8*l +: 8]),
      .new_b    (wlane[8*l +: 8]),
      .merged_b (merged[8*l +: 8])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[wi] <= merged;
    end
  end

  always_comb begin
    sel_b = cur[{bo, 3'b000} +: 8];
    sel_h = bo[1] ? cur[31:16] : cur[15:0];
    case (bus.ld_type)
      3'd1:    bus.rdata = {24'b0, sel_b};
      3'd2:    bus.rdata = {{24{sel_b[7]}}, sel_b};
      3'd3:    bus.rdata = {16'b0, sel_h};
      3'd4:    bus.rdata = {{16{sel_h[15]}}, sel_h};
      default: bus.rdata = cur;
    endcase
    if (bus.align_err) bus.rdata = '0;
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (we) $display("@%h: *%h <= %h", log_pc, {bus.addr[31:2], 2'b00}, merged);
  end
`endif
endmodule

// File: tb/tb_dm_unit.sv
// Directed + random bench for dm_unit against a byte-level reference memory.
module tb_dm_unit;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dm_unit_if #(.PC_WIDTH(32)) bus ();
  dm_unit #(.ADDR_WIDTH(AW), .PC_WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] last_rd;
  logic        last_al;
  int checks = 0;
  int errors = 0;

  function automatic logic exp_align(logic mw, logic [1:0] st, logic [2:0] ld, logic [31:0] a);
    int unsigned lsz, ssz;
    logic m;
    lsz = (ld == 1 || ld == 2) ? 1 : (ld == 3 || ld == 4) ? 2 : 4;
    ssz = (st == 0) ? 4 : (st == 1) ? 2 : 1;
    m = (a % lsz) != 0;
    if (mw && (a % ssz) != 0) m = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] exp_rdata(logic [2:0] ld, logic [31:0] a, logic al);
    logic [31:0] w, b, h;
    if (al) return 32'h0;
    w = ref_mem[(a / 4) % DEPTH];
    b = (w >> (8 * (a % 4))) & 32'hFF;
    h = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (ld)
      3'd1:    return b;
      3'd2:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'd3:    return h;
      3'd4:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
      default: return w;
    endcase
  endfunction

  task automatic model_store(logic [1:0] st, logic [31:0] a, logic [31:0] wd);
    int unsigned idx, k;
    logic [31:0] w;
    idx = (a / 4) % DEPTH;
    w = ref_mem[idx];
    if (st == 0) w = wd;
    else if (st == 1) begin
      k = (a / 2) % 2;
      w = (w & ~(32'hFFFF << (16 * k))) | ((wd & 32'hFFFF) << (16 * k));
    end else if (st == 2) begin
      k = a % 4;
      w = (w & ~(32'hFF << (8 * k))) | ((wd & 32'hFF) << (8 * k));
    end
    ref_mem[idx] = w;
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one access, check the combinational outputs, then clock it and update the model.
  task automatic step(string tag, logic rst, logic mw, logic [1:0] st, logic [2:0] ld,
                      logic [31:0] a, logic [31:0] wd);
    logic al;
    reset         = rst;
    bus.mem_write = mw;
    bus.st_type   = st;
    bus.ld_type   = ld;
    bus.addr      = a;
    bus.wdata     = wd;
    bus.pc        = bus.pc + 32'd4;
    #1;
    al = exp_align(mw, st, ld, a);
    last_rd = bus.rdata;
    last_al = bus.align_err;
    chk({tag, "_al"}, {31'b0, bus.align_err}, {31'b0, al});
    chk({tag, "_rd"}, bus.rdata, exp_rdata(ld, a, al));
    @(posedge clk);
    if (rst) for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    else if (mw && !al && st != 2'b11) model_store(st, a, wd);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.pc = 32'h0040_0000; bus.addr = '0; bus.wdata = '0;
    bus.mem_write = 1'b0; bus.st_type = 2'b00; bus.ld_type = 3'd0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    @(posedge clk); #1;
    reset = 1'b0;

    // reset state
    step("rst_lw0",   0, 0, 0, 0, 32'h0,   0); chk("rst_lit0", last_rd, 32'h0);
    step("rst_lw4",   0, 0, 0, 0, 32'h4,   0);
    step("rst_lwffc", 0, 0, 0, 0, 32'hFFC, 0); chk("rst_litffc", last_rd, 32'h0);

    // word store and extended loads
    step("sw10",  0, 1, 0, 0, 32'h10, 32'h12345678);
    step("lw10",  0, 0, 0, 0, 32'h10, 0); chk("lit_lw10", last_rd, 32'h12345678);
    step("lbu13", 0, 0, 0, 1, 32'h13, 0); chk("lit_lbu13", last_rd, 32'h12);
    step("lb10",  0, 0, 0, 2, 32'h10, 0); chk("lit_lb10", last_rd, 32'h78);
    step("lhu12", 0, 0, 0, 3, 32'h12, 0); chk("lit_lhu12", last_rd, 32'h1234);

    // byte and half merges
    step("sb11",  0, 1, 2, 1, 32'h11, 32'hAB);
    step("lw10b", 0, 0, 0, 0, 32'h10, 0); chk("lit_sb", last_rd, 32'h1234AB78);
    step("lb11",  0, 0, 0, 2, 32'h11, 0); chk("lit_lb11", last_rd, 32'hFFFFFFAB);
    step("lbu11", 0, 0, 0, 1, 32'h11, 0); chk("lit_lbu11", last_rd, 32'h000000AB);
    step("sh12",  0, 1, 1, 4, 32'h12, 32'h8001);
    step("lw10c", 0, 0, 0, 0, 32'h10, 0); chk("lit_sh", last_rd, 32'h8001AB78);
    step("lh12",  0, 0, 0, 4, 32'h12, 0); chk("lit_lh12", last_rd, 32'hFFFF8001);

    // misalignment
    step("sw0e",  0, 1, 0, 1, 32'h0E, 32'hDEADBEEF); chk("lit_sw0e_al", {31'b0, last_al}, 32'd1);
    step("lw0c",  0, 0, 0, 0, 32'h0C, 0);
    step("lw10d", 0, 0, 0, 0, 32'h10, 0); chk("lit_unch", last_rd, 32'h8001AB78);
    step("lh13",  0, 0, 0, 4, 32'h13, 0); chk("lit_lh13", last_rd, 32'h0);
    step("sh16",  0, 1, 1, 4, 32'h16, 32'hC0DE); chk("lit_sh16_al", {31'b0, last_al}, 32'd0);
    step("lhu16", 0, 0, 0, 3, 32'h16, 0); chk("lit_lhu16", last_rd, 32'hC0DE);

    // same-cycle store is not visible; aliasing
    step("swrd20", 0, 1, 0, 0, 32'h20, 32'hA5A5A5A5); chk("lit_old20", last_rd, 32'h0);
    step("lw20",   0, 0, 0, 0, 32'h20, 0); chk("lit_new20", last_rd, 32'hA5A5A5A5);
    step("sw1000", 0, 1, 0, 0, 32'h1000, 32'hCAFEF00D);
    step("lw0a",   0, 0, 0, 0, 32'h0, 0); chk("lit_alias", last_rd, 32'hCAFEF00D);

    // reset wins over a simultaneous store
    step("rstw",  1, 1, 0, 0, 32'h10, 32'hFFFFFFFF);
    step("lw10r", 0, 0, 0, 0, 32'h10, 0); chk("lit_rst10", last_rd, 32'h0);
    step("lw0r",  0, 0, 0, 0, 32'h0,  0); chk("lit_rst0", last_rd, 32'h0);
    step("sw24",  0, 1, 0, 0, 32'h24, 32'h0BADF00D);
    step("lw24",  0, 0, 0, 0, 32'h24, 0); chk("lit_resume", last_rd, 32'h0BADF00D);

    // random traffic over a small window with aliasing high bits
    for (int n = 0; n < 600; n++) begin
      logic [31:0] a;
      a = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      step("rnd", ($urandom_range(0, 99) == 0), $urandom_range(0, 1) != 0,
           2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), a, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
